cgra_ker_dispatcher: RTL and testbench

CGRA_KER_DISPATCHER -- requirements
Module: cgra_ker_dispatcher

---
 rtl/cgra_pkg.sv | 15 +
 rtl/cgra_col_alloc.sv | 29 ++
 rtl/cgra_ker_dispatcher.sv | 137 +++++++++++++
 tb/tb_cgra_ker_dispatcher.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_pkg.sv
// Shared types and constants for the CGRA kernel dispatcher.
package cgra_pkg;

    localparam int DEF_KER_CONF_N_REG_LOG2 = 4;
    localparam int N_SLOTS_LOG2            = 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WAIT_CONF = 3'd2,
        ALLOC     = 3'd3,
        GRANT     = 3'd4
    } disp_state_e;

endpackage

// File: rtl/cgra_col_alloc.sv
// Combinational search for the lowest-index run of ncol_i contiguous free columns.
module cgra_col_alloc #(
    parameter int N_COL = 4
) (
    input  logic [N_COL-1:0] busy_i,
    input  logic [2:0]       ncol_i,
    output logic             found_o,
    output logic [N_COL-1:0] mask_o
);

    logic [N_COL-1:0] win;

    always_comb begin
        found_o = 1'b0;
        mask_o  = '0;
        win     = '0;
        for (int s = 0; s < N_COL; s++) begin
            for (int b = 0; b < N_COL; b++)
                win[b] = (b >= s) && (b < s + int'(ncol_i));
            // a window running off the top edge is not a legal placement
            if (!found_o && ncol_i != 3'd0 && (s + int'(ncol_i) <= N_COL) &&
                ((busy_i & win) == '0)) begin
                found_o = 1'b1;
                mask_o  = win;
            end
        end
    end

endmodule

// File: rtl/cgra_ker_dispatcher.sv
// Kernel dispatcher: picks a request slot round-robin, reads the kernel's column
// count, allocates contiguous free columns and issues a one-cycle grant.
module cgra_ker_dispatcher
    import cgra_pkg::*;
#(
    parameter int N_COL               = 4,
    parameter int N_SLOTS             = 2,
    parameter int KER_CONF_N_REG_LOG2 = DEF_KER_CONF_N_REG_LOG2
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [N_SLOTS-1:0][KER_CONF_N_REG_LOG2-1:0] ker_id_i,
    input  logic [N_COL-1:0]                        col_status_i,
    output logic                                    conf_req_o,
    output logic [KER_CONF_N_REG_LOG2-1:0]          conf_addr_o,
    input  logic [2:0]                              conf_ncol_i,
    output logic [N_COL-1:0]                        acc_req_o,
    output logic                                    acc_ack_o,
    output logic [N_SLOTS_LOG2-1:0]                 c_id_req_clear_o,
    output logic [N_COL-1:0]                        col_start_o,
    output logic [KER_CONF_N_REG_LOG2-1:0]          start_ker_id_o,
    input  logic [N_COL-1:0]                        col_done_i,
    output logic [N_COL-1:0]                        acc_end_o,
    output logic                                    err_o
);

    disp_state_e                    state_q, state_d;
    logic [N_SLOTS_LOG2-1:0]        slot_q, slot_d, rr_q, rr_d, idx;
    logic [KER_CONF_N_REG_LOG2-1:0] id_q, id_d;
    logic [2:0]                     ncol_q, ncol_d;
    logic [N_COL-1:0]               mask_q, mask_d, pend_q, acc_end_q;
    logic [N_COL-1:0]               alloc_mask;
    logic                           alloc_found, hit, req_live, ncol_bad, fire;

    // pend_q covers the cycle before col_status_i reflects the last grant
    cgra_col_alloc #(.N_COL(N_COL)) u_alloc (
        .busy_i  (col_status_i | pend_q),
        .ncol_i  (ncol_q),
        .found_o (alloc_found),
        .mask_o  (alloc_mask)
    );

    assign req_live  = (ker_id_i[slot_q] != '0);
    assign ncol_bad  = (ncol_q == 3'd0) || (int'(ncol_q) > N_COL);
    assign acc_end_o = acc_end_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            rr_q      <= '0;
            id_q      <= '0;
            ncol_q    <= '0;
            mask_q    <= '0;
            pend_q    <= '0;
            acc_end_q <= '0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            rr_q      <= rr_d;
            id_q      <= id_d;
            ncol_q    <= ncol_d;
            mask_q    <= mask_d;
            pend_q    <= fire ? mask_q : '0;
            acc_end_q <= col_done_i;
        end
    end

    always_comb begin
        state_d          = state_q;
        slot_d           = slot_q;
        rr_d             = rr_q;
        id_d             = id_q;
        ncol_d           = ncol_q;
        mask_d           = mask_q;
        hit              = 1'b0;
        idx              = '0;
        fire             = 1'b0;
        conf_req_o       = 1'b0;
        conf_addr_o      = '0;
        acc_req_o        = '0;
        acc_ack_o        = 1'b0;
        c_id_req_clear_o = '0;
        col_start_o      = '0;
        start_ker_id_o   = '0;
        err_o            = 1'b0;
        unique case (state_q)
            IDLE: begin
                for (int i = 0; i < N_SLOTS; i++) begin
                    idx = N_SLOTS_LOG2'((int'(rr_q) + i) % N_SLOTS);
                    if (!hit && ker_id_i[idx] != '0) begin
                        hit    = 1'b1;
                        slot_d = idx;
                        id_d   = ker_id_i[idx];
                    end
                end
                if (hit) state_d = LOOKUP;
            end
            LOOKUP: begin
                conf_req_o  = 1'b1;
                conf_addr_o = id_q;
                state_d     = req_live ? WAIT_CONF : IDLE;
            end
            WAIT_CONF: begin
                ncol_d  = conf_ncol_i;
                state_d = req_live ? ALLOC : IDLE;
            end
            ALLOC: begin
                if (!req_live) begin
                    state_d = IDLE;
                end else if (ncol_bad) begin
                    err_o   = 1'b1;
                    mask_d  = '0;
                    state_d = GRANT;
                end else if (alloc_found) begin
                    mask_d  = alloc_mask;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // hold off while an end is landing so status never sees both at once
                if (acc_end_q == '0) begin
                    fire             = 1'b1;
                    acc_ack_o        = 1'b1;
                    acc_req_o        = mask_q;
                    col_start_o      = mask_q;
                    c_id_req_clear_o = slot_q;
                    start_ker_id_o   = id_q;
                    rr_d             = N_SLOTS_LOG2'((int'(slot_q) + 1) % N_SLOTS);
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cgra_ker_dispatcher.sv
// Self-checking bench for cgra_ker_dispatcher: directed scenarios plus randomized requests.
module tb_cgra_ker_dispatcher;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0][3:0]  ker_id = '0;
    logic [3:0]       col_status, drv_status = '0, env_status;
    logic             env_mode = 1'b0;
    logic             conf_req;
    logic [3:0]       conf_addr;
    logic [2:0]       conf_ncol = '0, cur_ncol = '0;
    logic [3:0]       acc_req;
    logic             acc_ack;
    logic [0:0]       c_id_clr;
    logic [3:0]       col_start;
    logic [3:0]       start_id;
    logic [3:0]       col_done = '0;
    logic [3:0]       acc_end;
    logic             err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cgra_ker_dispatcher #(.N_COL(4), .N_SLOTS(2), .KER_CONF_N_REG_LOG2(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .ker_id_i(ker_id), .col_status_i(col_status),
        .conf_req_o(conf_req), .conf_addr_o(conf_addr), .conf_ncol_i(conf_ncol),
        .acc_req_o(acc_req), .acc_ack_o(acc_ack), .c_id_req_clear_o(c_id_clr),
        .col_start_o(col_start), .start_ker_id_o(start_id), .col_done_i(col_done),
        .acc_end_o(acc_end), .err_o(err)
    );

    // Config memory answers the cycle after the read strobe.
    always @(posedge clk) if (conf_req) conf_ncol <= cur_ncol;

    // Environment column-status register: set by grants, cleared by ends.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) env_status <= '0;
        else        env_status <= (env_status | acc_req) & ~acc_end;

    assign col_status = env_mode ? env_status : drv_status;

    // Reference: lowest start s such that n columns from s are all free.
    function automatic logic [3:0] model_alloc(input int busy, input int n, output bit ok);
        int run;
        ok = 1'b0;
        if (n < 1 || n > 4) return 4'd0;
        run = (1 << n) - 1;
        for (int s = 0; s + n <= 4; s++)
            if (((busy >> s) & run) == 0) begin
                ok = 1'b1;
                return 4'((run << s) & 15);
            end
        return 4'd0;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; ker_id = '0; col_done = '0; drv_status = '0; env_mode = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Waits for an ack; on ack the requester withdraws the granted slot.
    task automatic wait_ack(input int maxc, output bit got, output int lat, output logic [3:0] m,
                            output int s, output int kid, output bit err_seen, output int addr);
        got = 0; lat = 0; m = '0; s = -1; kid = -1; err_seen = 0; addr = -1;
        for (int c = 0; c < maxc; c++) begin
            @(negedge clk);
            lat++;
            if (err) err_seen = 1;
            if (conf_req) addr = int'(conf_addr);
            if (acc_ack) begin
                got = 1; m = acc_req; s = int'(c_id_clr); kid = int'(start_id);
                if (col_start !== acc_req) begin
                    n_bad++; $display("FAIL col_start: got %b want %b", col_start, acc_req);
                end
                ker_id[s] = '0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({conf_req, conf_addr, acc_req, acc_ack, c_id_clr, col_start, start_id, acc_end, err} !== '0) begin
            n_bad++; $display("FAIL reset_outputs: got nonzero outputs, want all 0");
        end
        do_reset();
    endtask

    task automatic test_single();
        bit got, e; int lat, s, kid, addr; logic [3:0] m;
        do_reset();
        cur_ncol = 3'd2; ker_id[0] = 4'd3;
        wait_ack(10, got, lat, m, s, kid, e, addr);
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL single_ack: got %0d want 1", got); end
        n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL single_latency: got %0d want 4", lat); end
        n_cmp++; if (m !== 4'b0011) begin n_bad++; $display("FAIL single_mask: got %b want 0011", m); end
        n_cmp++; if (s != 0) begin n_bad++; $display("FAIL single_slot: got %0d want 0", s); end
        n_cmp++; if (kid != 3) begin n_bad++; $display("FAIL single_id: got %0d want 3", kid); end
        n_cmp++; if (addr != 3) begin n_bad++; $display("FAIL single_conf_addr: got %0d want 3", addr); end
    endtask

    task automatic test_busy_cols();
        bit got, e; int lat, s, kid, addr; logic [3:0] m;
        do_reset();
        drv_status = 4'b0011; cur_ncol = 3'd2; ker_id[1] = 4'd7;
        wait_ack(10, got, lat, m, s, kid, e, addr);
        n_cmp++; if (m !== 4'b1100 || !got) begin n_bad++; $display("FAIL busy_mask: got %b want 1100", m); end
        n_cmp++; if (s != 1) begin n_bad++; $display("FAIL busy_slot: got %0d want 1", s); end
    endtask

    task automatic test_stall();
        bit got, e, ok; int lat, s, kid, addr; logic [3:0] m, exp_m;
        do_reset();
        drv_status = 4'b0101; cur_ncol = 3'd2; ker_id[0] = 4'd5;
        wait_ack(8, got, lat, m, s, kid, e, addr);
        n_cmp++; if (got) begin n_bad++; $display("FAIL stall_no_ack: got ack, want none"); end
        col_done = 4'b0100;
        @(negedge clk);
        col_done = 4'b0000;
        n_cmp++; if (acc_end !== 4'b0100) begin n_bad++; $display("FAIL stall_acc_end: got %b want 0100", acc_end); end
        drv_status = 4'b0001;
        exp_m = model_alloc(1, 2, ok);
        wait_ack(6, got, lat, m, s, kid, e, addr);
        n_cmp++; if (!got || m !== exp_m) begin n_bad++; $display("FAIL stall_grant: got %b want %b", m, exp_m); end
    endtask

    task automatic test_back_to_back();
        bit got, e; int lat, s, kid, addr; logic [3:0] m;
        do_reset();
        env_mode = 1'b1; cur_ncol = 3'd1; ker_id[0] = 4'd1; ker_id[1] = 4'd2;
        wait_ack(10, got, lat, m, s, kid, e, addr);
        n_cmp++; if (!got || s != 0 || m !== 4'b0001) begin n_bad++; $display("FAIL rr_first: got slot %0d mask %b want slot 0 mask 0001", s, m); end
        wait_ack(10, got, lat, m, s, kid, e, addr);
        n_cmp++; if (!got || s != 1 || m !== 4'b0010 || kid != 2) begin n_bad++; $display("FAIL rr_second: got slot %0d mask %b id %0d want slot 1 mask 0010 id 2", s, m, kid); end
    endtask

    task automatic test_err();
        bit got, e; int lat, s, kid, addr; logic [3:0] m;
        do_reset();
        cur_ncol = 3'd5; ker_id[0] = 4'd9;
        wait_ack(10, got, lat, m, s, kid, e, addr);
        n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL err_pulse: got %0d want 1", e); end
        n_cmp++; if (!got || m !== 4'b0000 || lat != 4) begin n_bad++; $display("FAIL err_grant: got ack %0d mask %b lat %0d want 1 0000 4", got, m, lat); end
    endtask

    task automatic test_end_collision();
        bit got, e; int lat, s, kid, addr; logic [3:0] m;
        do_reset();
        cur_ncol = 3'd1; ker_id[0] = 4'd4;
        repeat (3) @(negedge clk);
        col_done = 4'b1000;
        @(negedge clk);
        col_done = 4'b0000;
        n_cmp++; if (acc_ack !== 1'b0 || acc_end !== 4'b1000 || acc_req !== 4'b0000) begin
            n_bad++; $display("FAIL collide_hold: got ack %0d end %b req %b want 0 1000 0000", acc_ack, acc_end, acc_req);
        end
        wait_ack(4, got, lat, m, s, kid, e, addr);
        n_cmp++; if (!got || lat != 1 || m !== 4'b0001) begin n_bad++; $display("FAIL collide_grant: got ack %0d lat %0d mask %b want 1 1 0001", got, lat, m); end
    endtask

    task automatic test_reset_midflight();
        bit got, e; int lat, s, kid, addr; logic [3:0] m;
        do_reset();
        cur_ncol = 3'd1; ker_id[0] = 4'd6;
        repeat (2) @(negedge clk);
        rst_n = 1'b0; ker_id = '0;
        #1;
        n_cmp++;
        if ({conf_req, conf_addr, acc_req, acc_ack, c_id_clr, col_start, start_id, acc_end, err} !== '0) begin
            n_bad++; $display("FAIL midreset_outputs: got nonzero outputs, want all 0");
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_ack(8, got, lat, m, s, kid, e, addr);
        n_cmp++; if (got) begin n_bad++; $display("FAIL midreset_no_ack: got ack, want none"); end
    endtask

    task automatic test_drop();
        bit got, e; int lat, s, kid, addr; logic [3:0] m;
        do_reset();
        drv_status = 4'b1111; cur_ncol = 3'd1; ker_id[1] = 4'd6;
        repeat (5) @(negedge clk);
        ker_id[1] = 4'd0; drv_status = 4'b0000;
        wait_ack(8, got, lat, m, s, kid, e, addr);
        n_cmp++; if (got) begin n_bad++; $display("FAIL drop_no_ack: got ack, want none"); end
    endtask

    task automatic test_random();
        bit got, e, ok; int lat, s, kid, addr, slot, id, n, st; logic [3:0] m, exp_m;
        do_reset();
        for (int it = 0; it < 24; it++) begin
            slot = $urandom_range(0, 1); id = $urandom_range(1, 15);
            n = $urandom_range(0, 5);    st = $urandom_range(0, 15);
            drv_status = 4'(st); cur_ncol = 3'(n); ker_id[slot] = 4'(id);
            exp_m = model_alloc(st, n, ok);
            if (n >= 1 && n <= 4 && !ok) begin
                wait_ack(8, got, lat, m, s, kid, e, addr);
                n_cmp++; if (got) begin n_bad++; $display("FAIL rnd_stall it%0d: got ack, want none", it); end
                drv_status = 4'b0000;
                exp_m = model_alloc(0, n, ok);
            end
            wait_ack(8, got, lat, m, s, kid, e, addr);
            n_cmp++;
            if (!got || m !== exp_m || s != slot || kid != id || e != (n < 1 || n > 4)) begin
                n_bad++;
                $display("FAIL rnd_grant it%0d: got ack %0d mask %b slot %0d id %0d err %0d want mask %b slot %0d id %0d n %0d",
                         it, got, m, s, kid, e, exp_m, slot, id, n);
            end
            if (!got) ker_id[slot] = '0;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_busy_cols();
        test_stall();
        test_back_to_back();
        test_err();
        test_end_collision();
        test_reset_midflight();
        test_drop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
